// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_addsub_pkg : shared FSM state type and op encodings.
// Revision: 1.0
// ---------------------------------------------------------------------------
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_ctrl_csa.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_addsub_ctrl_csa : one-bit full adder whose 'a' input is XORed with ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_addsub_ctrl_csa (
  input  logic a,
  input  logic b,
  input  logic ctrl,
  input  logic cin,
  output logic o,
  output logic cout
);

  logic ax;

  assign ax   = a ^ ctrl;
  assign o    = ax ^ b ^ cin;
  assign cout = (ax & b) | (ax & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_addsub_ctrl : LSB-first bit-serial add/subtract with valid/ready I/O.
// Optional status outputs (out_zero, out_neg) under SERIAL_ADDSUB_STATUS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
`ifdef SERIAL_ADDSUB_STATUS_EN
  ,
  output logic         out_zero,
  output logic         out_neg
`endif
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  state_t           state;
  logic [W-1:0]     sa;
  logic [W-1:0]     sb;
  logic [W-1:0]     res;
  logic             op_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             csa_o;
  logic             csa_cout;
`ifdef SERIAL_ADDSUB_STATUS_EN
  logic             zero_acc;
`endif

  // Subtract is a + ~b + 1: b rides on the conditioned input, cin preloaded with op.
  serial_addsub_ctrl_csa u_csa (
    .a    (sb[0]),
    .b    (sa[0]),
    .ctrl (op_q),
    .cin  (carry),
    .o    (csa_o),
    .cout (csa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      op_q      <= OP_ADD;
`ifdef SERIAL_ADDSUB_STATUS_EN
      zero_acc  <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa       <= in_a;
            sb       <= in_b;
            op_q     <= in_op;
            carry    <= (in_op == OP_SUB);
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef SERIAL_ADDSUB_STATUS_EN
            zero_acc <= 1'b1;
`endif
          end
        end
        RUN: begin
          res   <= {csa_o, res[W-1:1]};
          carry <= csa_cout;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
`ifdef SERIAL_ADDSUB_STATUS_EN
          zero_acc <= zero_acc & ~csa_o;
`endif
          if (cnt == LAST_BIT) begin
            // Overflow: carry into the sign bit differs from carry out of it.
            out_sum   <= {csa_o, res[W-1:1]};
            out_cout  <= csa_cout;
            out_ovf   <= carry ^ csa_cout;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
`ifdef SERIAL_ADDSUB_STATUS_EN
            out_zero  <= zero_acc & ~csa_o;
            out_neg   <= csa_o;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_addsub_ctrl : directed self-checking bench for serial_addsub_ctrl (W=8).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;
`ifdef SERIAL_ADDSUB_STATUS_EN
  logic         out_zero;
  logic         out_neg;
`endif

  int errors = 0;
  int checks = 0;

  serial_addsub_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
`ifdef SERIAL_ADDSUB_STATUS_EN
    ,
    .out_zero  (out_zero),
    .out_neg   (out_neg)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, wait for out_valid, check latency and result fields.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op, input logic [W-1:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf, input logic early);
    int cyc;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    out_ready = early;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(W));
    check({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(out_cout), 64'(exp_cout));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_done_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] held;

    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(out_sum), 64'd0);
    check("rst_cout", 64'(out_cout), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    do_op("add5p3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    do_op("sub5m3", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    do_op("sub3m5", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADDSUB_STATUS_EN
    check("sub3m5_neg", 64'(out_neg), 64'd1);
    check("sub3m5_zero", 64'(out_zero), 64'd0);
`endif
    do_op("ovf_add", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    do_op("ovf_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Backpressure plus ignored in_valid during RUN and at completion.
    in_valid = 1'b1; in_a = 8'h21; in_b = 8'h12; in_op = 1'b0;
    tick();
    in_a = 8'hAA; in_b = 8'h11; in_op = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (in_ready) check("run_in_ready", 64'(in_ready), 64'd0);
      tick();
      cyc++;
    end
    check("bp_latency", 64'(cyc), 64'(W));
    check("bp_sum", 64'(out_sum), 64'h33);
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_stable", 64'(out_sum), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_a = 8'h10; in_b = 8'h20; in_op = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("cmpl_busy", 64'(busy), 64'd0);
    check("cmpl_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("reaccept_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("reaccept_sum", 64'(out_sum), 64'h30);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset four cycles into RUN.
    in_valid = 1'b1; in_a = 8'h44; in_b = 8'h22; in_op = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_sum", 64'(out_sum), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("add_ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef SERIAL_ADDSUB_STATUS_EN
    check("ff01_zero", 64'(out_zero), 64'd1);
    check("ff01_neg", 64'(out_neg), 64'd0);
`endif
    check("idle_hold_sum", 64'(out_sum), 64'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer built around one shared csa cell (XOR-conditioned full adder).
- Accepts W-bit operands over a valid/ready handshake.
- Steps LSB-first through the csa cell, one bit per clock, holding the carry in a flop.
- Returns the W-bit result with carry and overflow over a second valid/ready handshake.
- Serves area-constrained datapaths where a full W-bit adder is too costly.

Parameters:
- W, 8, operand/result width; legal range 2..64.
- CNT_W, $clog2(W), bit-index counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all flops rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands (high only in IDLE).
- in_a  in  W  minuend/addend.
- in_b  in  W  subtrahend/addend.
- in_op  in  1  0 = add (a+b), 1 = subtract (a-b).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  result, two's complement, modulo 2^W.
- out_cout  out  1  final carry; for subtract, 1 = no borrow.
- out_ovf  out  1  signed overflow.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async, rst_n low) gives:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - out_sum = 0, out_cout = 0, out_ovf = 0.
  - Carry flop = 0, counter = 0.
- States IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_a into shift reg SA, in_b into SB, in_op into op_q.
  - Carry flop loads in_op (cin = 1 for subtract).
  - Counter = 0; go to RUN.
- RUN, one bit per cycle:
  - csa.b = SA[0]; csa.a = SB[0]; csa.ctrl = op_q; csa.cin = carry flop.
  - Subtract therefore computes a + ~b + 1.
  - csa.o shifts into the MSB of the result shift register.
  - Carry flop <= csa.cout.
  - SA and SB shift right.
  - When counter == W-1, latch out_cout = csa.cout and out_ovf = carry-in(bit W-1) XOR carry-out(bit W-1); go to DONE.
  - Otherwise counter += 1.
- Latency: exactly W cycles from the accept edge to the out_valid rising edge.
- DONE:
  - out_valid = 1; out_sum, out_cout and out_ovf are stable.
  - On out_ready: go to IDLE.
  - out_ready may be held high early; completion occurs on the first DONE cycle.
- Backpressure: out_ready low holds DONE indefinitely with outputs stable; in_ready stays 0.
- No accept in the DONE→IDLE transition cycle; in_ready rises the cycle after completion. Max throughput is one op per W+2 cycles.
- in_valid while not IDLE is ignored; operands are not sampled.
- in_a/in_b/in_op changes during RUN have no effect.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the pending result is discarded.
- out_sum is updated only at the end of RUN and holds its value through IDLE until the next result.

Optional Feature:
- Macro SERIAL_ADDSUB_STATUS_EN.
- Defined:
  - Adds out_zero (1 bit): high when the result is all zeros, tracked serially by ANDing the inverted sum bits.
  - Adds out_neg (1 bit): equals result MSB.
  - Both reset to 0 and are valid with out_valid.
- Undefined: ports absent; no added logic.

Decomposition:
- Shared package serial_addsub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - localparams OP_ADD = 1'b0, OP_SUB = 1'b1.
- One sub-module: the existing csa cell, instantiated once as the arithmetic element.
- Shift registers, counter and FSM stay inline.

Test Plan (W=8):
- Add, no overflow: a=0x05, b=0x03, op=0 → after 8 cycles out_sum=0x08, cout=0, ovf=0.
- Subtract, no borrow: a=0x05, b=0x03, op=1 → out_sum=0x02, cout=1, ovf=0.
- Subtract, borrow: a=0x03, b=0x05, op=1 → out_sum=0xFE, cout=0, ovf=0 (STATUS_EN: neg=1, zero=0).
- Signed overflow: a=0x7F, b=0x01, op=0 → out_sum=0x80, ovf=1, cout=0. Also a=0x80, b=0x01, op=1 → out_sum=0x7F, ovf=1.
- Backpressure and ignored inputs:
  - Hold out_ready=0 for 5 cycles: out_valid stays 1 with outputs stable, in_ready stays 0.
  - A second in_valid during RUN is not accepted.
  - A new op is accepted only after completion plus one cycle.
- Reset mid-operation: assert rst_n=0 at cycle 4 of RUN → out_valid=0, in_ready=1, out_sum=0 immediately. A following 0xFF+0x01 add yields out_sum=0x00, cout=1 (STATUS_EN: zero=1).
